// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg: shared constants, defaults and FSM state type for the config loader
package cfg_loader_pkg;
  localparam int WORD_W = 32;
  localparam int DEF_CLK_DIV = 2;
  localparam int DEF_PRST_CYCLES = 4;
  localparam int DEF_CNT_W = 20;
  localparam int DEF_FIFO_DEPTH = 4;
  typedef enum logic [2:0] {IDLE, PRST, SHIFT_LO, SHIFT_HI, DONE} state_t;
endpackage

// File: rtl/fabric_cfg_loader_if.sv
// fabric_cfg_loader_if: CPU bitstream word write channel
interface fabric_cfg_loader_if;
  import cfg_loader_pkg::*;
  logic wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic wr_ready;
  modport master(output wr_valid, wr_data, input wr_ready);
  modport slave(input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/cfg_word_fifo.sv
// cfg_word_fifo: first-word-fall-through word buffer with flush and registered flags
module cfg_word_fifo
  import cfg_loader_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_nxt;
  logic do_push, do_pop;
  always_comb begin
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    cnt_nxt = flush ? '0 : cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  assign rdata = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
  // flags come from the next count so they are registered, not decoded
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= flush ? '0 : wp + AW'(do_push);
      rp <= flush ? '0 : rp + AW'(do_pop);
      cnt <= cnt_nxt;
      full <= cnt_nxt == (AW+1)'(DEPTH);
      empty <= cnt_nxt == '0;
    end
  end
endmodule

// File: rtl/fabric_cfg_loader.sv
// fabric_cfg_loader: shifts a buffered bitstream into a fabric config chain with a generated prog_clk
module fabric_cfg_loader
  import cfg_loader_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int PRST_CYCLES = DEF_PRST_CYCLES,
  parameter int CNT_W = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  bit_count,
  input  logic              abort,
  fabric_cfg_loader_if.slave wr,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk,
  output logic              prog_reset,
  output logic              busy,
  output logic              bitstream_complt,
  output logic              op_clk_en,
  output logic [CNT_W-1:0]  bits_done,
  output logic [WORD_W-1:0] tail_shadow
);
  localparam int PW = $clog2(PRST_CYCLES + 1);
  state_t state;
  logic [7:0] phase;
  logic [PW-1:0] prst_cnt;
  logic [CNT_W-1:0] bit_target;
  logic [WORD_W-1:0] shift_reg, fifo_data;
  logic [4:0] word_bit;
  logic need_word, fifo_full, fifo_empty;
  logic pop, flush, prst_last, hi_last, finish, word_end, zero_start;
  cfg_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .push(wr.wr_valid),
    .pop(pop),
    .wdata(wr.wr_data),
    .rdata(fifo_data),
    .full(fifo_full),
    .empty(fifo_empty)
  );
  assign wr.wr_ready = !fifo_full;
  assign op_clk_en = bitstream_complt;
  // a word is popped on the edge that enters SHIFT_LO, or later while stalled there
  always_comb begin
    prst_last = state == PRST && prst_cnt == PW'(PRST_CYCLES - 1);
    hi_last = state == SHIFT_HI && phase == 8'(CLK_DIV - 1);
    finish = hi_last && bits_done == bit_target;
    word_end = word_bit == 5'(WORD_W - 1);
    zero_start = start && bit_count == '0 && (state == IDLE || state == DONE);
    pop = !abort && !fifo_empty &&
          (prst_last || (hi_last && !finish && word_end) || (state == SHIFT_LO && need_word));
    flush = abort || finish || zero_start;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      phase <= '0;
      prst_cnt <= '0;
      bit_target <= '0;
      bits_done <= '0;
      shift_reg <= '0;
      word_bit <= '0;
      need_word <= 1'b0;
      tail_shadow <= '0;
      prog_clk <= 1'b0;
      prog_reset <= 1'b0;
      ccff_head <= 1'b0;
      busy <= 1'b0;
      bitstream_complt <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      phase <= '0;
      need_word <= 1'b0;
      prog_clk <= 1'b0;
      prog_reset <= 1'b0;
      ccff_head <= 1'b0;
      busy <= 1'b0;
      bitstream_complt <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          bit_target <= bit_count;
          bits_done <= '0;
          if (bit_count == '0) begin
            state <= DONE;
            bitstream_complt <= 1'b1;
          end else begin
            state <= PRST;
            prst_cnt <= '0;
            prog_reset <= 1'b1;
            busy <= 1'b1;
            tail_shadow <= '0;
            bitstream_complt <= 1'b0;
          end
        end
        PRST: if (prst_last) begin
          state <= SHIFT_LO;
          prog_reset <= 1'b0;
          phase <= '0;
          need_word <= 1'b1;
        end else prst_cnt <= prst_cnt + 1'b1;
        SHIFT_LO: if (!need_word) begin
          if (phase == 8'(CLK_DIV - 1)) begin
            state <= SHIFT_HI;
            phase <= '0;
            prog_clk <= 1'b1;
            tail_shadow <= {tail_shadow[WORD_W-2:0], ccff_tail};
            bits_done <= bits_done + CNT_W'(bits_done != '1);
          end else phase <= phase + 1'b1;
        end
        SHIFT_HI: if (hi_last) begin
          prog_clk <= 1'b0;
          phase <= '0;
          if (finish) begin
            state <= DONE;
            ccff_head <= 1'b0;
            busy <= 1'b0;
            bitstream_complt <= 1'b1;
          end else begin
            state <= SHIFT_LO;
            if (word_end) need_word <= 1'b1;
            else begin
              shift_reg <= shift_reg << 1;
              ccff_head <= shift_reg[WORD_W-2];
              word_bit <= word_bit + 1'b1;
            end
          end
        end else phase <= phase + 1'b1;
        default: state <= IDLE;
      endcase
      if (pop) begin
        shift_reg <= fifo_data;
        ccff_head <= fifo_data[WORD_W-1];
        word_bit <= '0;
        need_word <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fabric_cfg_loader.sv
// tb_fabric_cfg_loader: directed checks of reset, shifting, stall, loopback, abort and zero-length loads
module tb_fabric_cfg_loader;
  logic clk = 0, rst = 1, start = 0, abort = 0, loop = 0;
  logic [19:0] bit_count = 0;
  logic ccff_head, ccff_tail, prog_clk, prog_reset, busy, bitstream_complt, op_clk_en;
  logic [19:0] bits_done;
  logic [31:0] tail_shadow;
  int total = 0, bad = 0, cyc = 0, prst_n = 0;
  logic pc_prev = 0;
  logic heads[$];
  int rises[$];
  fabric_cfg_loader_if wr();
  fabric_cfg_loader dut (
    .clk(clk), .rst(rst), .start(start), .bit_count(bit_count), .abort(abort), .wr(wr),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .prog_clk(prog_clk), .prog_reset(prog_reset),
    .busy(busy), .bitstream_complt(bitstream_complt), .op_clk_en(op_clk_en),
    .bits_done(bits_done), .tail_shadow(tail_shadow)
  );
  assign ccff_tail = loop ? ccff_head : 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (prog_clk && !pc_prev) begin
      heads.push_back(ccff_head);
      rises.push_back(cyc);
    end
    if (prog_reset) prst_n++;
    pc_prev = prog_clk;
    cyc++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] seq(input int from, input int n);
    logic [31:0] v = 0;
    for (int i = 0; i < n; i++) v = {v[30:0], heads[from+i]};
    return v;
  endfunction
  task automatic clr();
    heads.delete();
    rises.delete();
    prst_n = 0;
  endtask
  task automatic put(input logic [31:0] w);
    int n = 0;
    while (!wr.wr_ready && n < 500) begin @(negedge clk); n++; end
    if (!wr.wr_ready) chk("put_tmo", wr.wr_ready, 1);
    wr.wr_valid = 1;
    wr.wr_data = w;
    @(negedge clk);
    wr.wr_valid = 0;
  endtask
  task automatic kick(input logic [19:0] n);
    start = 1;
    bit_count = n;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while (!bitstream_complt && n < 2000) begin @(negedge clk); n++; end
    if (!bitstream_complt) chk({tag, "_tmo"}, bitstream_complt, 1);
  endtask
  task automatic wait_bits(input logic [19:0] b, input string tag);
    int n = 0;
    while (bits_done != b && n < 2000) begin @(negedge clk); n++; end
    if (bits_done != b) chk({tag, "_tmo"}, bits_done, b);
  endtask
  initial begin
    int badp, hi_n, n;
    wr.wr_valid = 0;
    wr.wr_data = 0;
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_outs", {prog_clk, prog_reset, ccff_head, bitstream_complt, op_clk_en, busy}, 0);
    chk("rst_bits", bits_done, 0);
    chk("rst_shadow", tail_shadow, 0);
    chk("rst_ready", wr.wr_ready, 1);
    // basic 8-bit load
    clr();
    put(32'hA500_0000);
    kick(8);
    chk("busy_run", busy, 1);
    wait_done("t1");
    chk("t1_edges", heads.size(), 8);
    chk("t1_seq", seq(0, 8), 32'hA5);
    badp = 0;
    for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 4) badp++;
    chk("t1_period", badp, 0);
    chk("t1_prst", prst_n, 4);
    chk("t1_bits", bits_done, 8);
    chk("t1_flags", {bitstream_complt, op_clk_en, busy, prog_clk, ccff_head}, 5'b11000);
    // 70 bits with a stall between word 1 and word 2
    clr();
    put(32'h1234_5678);
    kick(70);
    wait_bits(32, "t2_w1");
    n = 0;
    while (prog_clk && n < 20) begin @(negedge clk); n++; end
    hi_n = 0;
    repeat (20) begin
      @(negedge clk);
      if (prog_clk) hi_n++;
    end
    chk("t2_stall_lo", hi_n, 0);
    chk("t2_stall_bits", bits_done, 32);
    put(32'h9ABC_DEF0);
    put(32'hB400_0000);
    wait_done("t2");
    chk("t2_edges", heads.size(), 70);
    chk("t2_w1", seq(0, 32), 32'h1234_5678);
    chk("t2_w2", seq(32, 32), 32'h9ABC_DEF0);
    chk("t2_w3", seq(64, 6), 32'h2D);
    chk("t2_bits", bits_done, 70);
    // loopback tail capture
    clr();
    loop = 1;
    put(32'hDEAD_BEEF);
    kick(32);
    wait_done("t3");
    chk("t3_shadow", tail_shadow, 32'hDEAD_BEEF);
    loop = 0;
    // abort mid-load with a second word still buffered
    clr();
    put(32'hFFFF_0000);
    put(32'h0F0F_0F0F);
    kick(32);
    wait_bits(5, "t4");
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("t4_abort", {busy, bitstream_complt, prog_clk, prog_reset}, 0);
    chk("t4_ready", wr.wr_ready, 1);
    clr();
    put(32'h3C00_0000);
    kick(8);
    @(negedge clk);
    kick(2);
    wait_done("t4b");
    chk("t4_seq", seq(0, 8), 32'h3C);
    chk("t4_edges", heads.size(), 8);
    // abort beats a simultaneous start
    start = 1;
    abort = 1;
    bit_count = 8;
    @(negedge clk);
    start = 0;
    abort = 0;
    chk("abort_wins", {busy, bitstream_complt, prog_reset}, 0);
    // zero-length load
    clr();
    kick(0);
    chk("t5_done", {bitstream_complt, op_clk_en, busy}, 3'b110);
    repeat (10) @(negedge clk);
    chk("t5_prst", prst_n, 0);
    chk("t5_edges", heads.size(), 0);
    // reset during SHIFT_HI
    put(32'hFFFF_FFFF);
    put(32'h0000_0001);
    kick(32);
    n = 0;
    while (!prog_clk && n < 200) begin @(negedge clk); n++; end
    chk("t6_hi", prog_clk, 1);
    rst = 1;
    @(negedge clk);
    chk("t6_outs", {prog_clk, prog_reset, ccff_head, bitstream_complt, op_clk_en, busy}, 0);
    chk("t6_bits", bits_done, 0);
    chk("t6_shadow", tail_shadow, 0);
    chk("t6_ready", wr.wr_ready, 1);
    rst = 0;
    @(negedge clk);
    clr();
    put(32'h5A00_0000);
    kick(8);
    wait_done("t6b");
    chk("t6_seq", seq(0, 8), 32'h5A);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fabric_cfg_loader.md
FABRIC_CFG_LOADER -- requirements
Module: fabric_cfg_loader

Interface
REQ-001 SHALL have parameter CLK_DIV, default 2: prog_clk half-period in clk cycles; legal range 1..255.
REQ-002 SHALL have parameter PRST_CYCLES, default 4: prog_reset pulse length in clk cycles.
REQ-003 SHALL have parameter CNT_W, default 20: width of the bit counter.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: number of 32-bit words buffered; power of two.
REQ-005 clk  in  1  single clock; all logic runs on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse; latches bit_count and begins a load.
REQ-008 bit_count  in  CNT_W  number of configuration bits to shift.
REQ-009 abort  in  1  stops the load and returns to IDLE.
REQ-010 wr_valid  in  1  the CPU offers a bitstream word.
REQ-011 wr_data  in  32  bitstream word; shifted out MSB first.
REQ-012 wr_ready  out  1  FIFO not full.
REQ-013 ccff_head  out  1  serial data to the head of the fabric config chain.
REQ-014 ccff_tail  in  1  serial data from the tail of the fabric config chain.
REQ-015 prog_clk  out  1  config chain clock, generated from clk and registered.
REQ-016 prog_reset  out  1  config chain reset, active-high.
REQ-017 busy  out  1  state is neither IDLE nor DONE.
REQ-018 bitstream_complt  out  1  load finished; held high until the next start or rst.
REQ-019 op_clk_en  out  1  fabric operating clock gate enable; equals bitstream_complt.
REQ-020 bits_done  out  CNT_W  count of prog_clk rising edges in the current load.
REQ-021 tail_shadow  out  32  last 32 ccff_tail samples; the newest sample is in bit 0.

Function
REQ-022 FSM states SHALL be IDLE, PRST, SHIFT_LO, SHIFT_HI and DONE.
REQ-023 IDLE/DONE + start: bit_count==0 -> DONE next cycle; otherwise -> PRST, clear bits_done and tail_shadow, deassert bitstream_complt.
REQ-024 PRST SHALL hold prog_reset=1 for exactly PRST_CYCLES cycles, then -> SHIFT_LO.
REQ-025 SHIFT_LO: prog_clk=0; ccff_head=shift_reg[31] valid the whole phase; lasts CLK_DIV cycles, then -> SHIFT_HI.
REQ-026 SHIFT_HI: prog_clk=1 for CLK_DIV cycles; on the entry cycle sample ccff_tail into tail_shadow and increment bits_done.
REQ-027 At the end of SHIFT_HI: if bits_done==bit_count -> DONE; otherwise shift shift_reg left by 1 and -> SHIFT_LO.
REQ-028 After 32 bits of a word are used, the next word SHALL be popped from the FIFO at the start of SHIFT_LO.
REQ-029 If the FIFO is empty when a word is needed, stay in SHIFT_LO with prog_clk=0 and the phase counter frozen (stall); no bit is lost or duplicated.
REQ-030 The first word SHALL be popped on the PRST->SHIFT_LO transition, subject to the same stall rule.
REQ-031 Leftover bits of a partial final word SHALL be discarded at DONE; the FIFO SHALL be flushed on entry to DONE.
REQ-032 DONE SHALL drive bitstream_complt=1, op_clk_en=1, prog_clk=0, ccff_head=0.
REQ-033 abort in any state -> IDLE next cycle: FIFO flushed, prog_clk=0, prog_reset=0, bitstream_complt=0.
REQ-034 abort and start in the same cycle: abort wins.
REQ-035 start while busy SHALL be ignored.
REQ-036 A FIFO write and pop in the same cycle SHALL both take effect; a write while full is dropped (wr_ready=0).
REQ-037 bits_done SHALL saturate at 2^CNT_W-1.

Reset
REQ-038 rst -> IDLE.
REQ-039 rst SHALL force all outputs low: prog_clk=0, prog_reset=0, ccff_head=0, bitstream_complt=0, op_clk_en=0, busy=0, bits_done=0, tail_shadow=0.
REQ-040 rst SHALL empty the FIFO, so wr_ready=1 on the first cycle after reset.
REQ-041 rst mid-load SHALL behave as abort and additionally clear all counters.

Structure
REQ-042 A shared package cfg_loader_pkg SHALL hold the FSM state enum, the word width constant (32) and the default parameters.
REQ-043 The FIFO SHALL be a sub-module cfg_word_fifo: synchronous, first-word-fall-through, flush input, full/empty outputs.
REQ-044 All outputs SHALL be driven from registers; the design is a single clock domain.

Verification
REQ-045 CLK_DIV=2, bit_count=8, one word 0xA5000000 -> ccff_head sequence 1,0,1,0,0,1,0,1; 8 prog_clk pulses of 4-cycle period; complt high; bits_done=8.
REQ-046 bit_count=70, three words written, 20-cycle write gap after word 1 -> prog_clk low throughout the stall; 70 edges total; bits 64..69 = word 3 MSBs.
REQ-047 Loop ccff_tail to ccff_head, 32 bits of 0xDEADBEEF -> tail_shadow=0xDEADBEEF.
REQ-048 abort after bit 5 of a 32-bit load -> IDLE next cycle; complt=0; wr_ready=1; a new start runs cleanly.
REQ-049 bit_count=0 -> DONE one cycle after start; no prog_reset pulse; no prog_clk edge.
REQ-050 rst asserted in SHIFT_HI -> next cycle all outputs 0; FIFO empty.
